// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array I/O buffers.
// Capture-state encoding and common frame dimensions.
package sa_pkg;

    typedef enum logic {FILL, FULL} wbuf_state_t;

    localparam int SA_X_W   = 16;
    localparam int SA_DEPTH = 8;

endpackage

// File: rtl/buf_regfile.sv
// Frame storage: one synchronous write port, one registered read port.
// Reads see the old word on a same-address write; out-of-range reads give 0.
module buf_regfile #(
    parameter  int x_w   = 16,
    parameter  int depth = 8,
    localparam int aw    = $clog2(depth)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [aw-1:0] waddr_i,
    input  logic [x_w-1:0] wdata_i,
    input  logic          re_i,
    input  logic [aw-1:0] raddr_i,
    output logic [x_w-1:0] rdata_o,
    output logic          rv_o
);

    localparam logic [aw:0] DEPTH_L = (aw+1)'(depth);

    logic [x_w-1:0] mem [depth];
    logic           in_range;

    assign in_range = {1'b0, raddr_i} < DEPTH_L;

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds the last word when idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o <= '0;
            rv_o    <= 1'b0;
        end else begin
            rv_o <= re_i;
            if (re_i) begin
                rdata_o <= in_range ? mem[raddr_i] : '0;
            end
        end
    end

endmodule

// File: rtl/write_buf.sv
// Output capture buffer: fills a frame of samples in arrival order,
// flags completion, and serves random-access reads until cleared.
module write_buf
    import sa_pkg::*;
#(
    parameter  int x_w   = SA_X_W,
    parameter  int depth = SA_DEPTH,
    localparam int aw    = $clog2(depth)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [x_w-1:0] d_i,
    input  logic           v_vi,
    input  logic           clear_i,
    output logic [aw:0]    cnt_o,
    output logic           full_o,
    output logic           done_vo,
    output logic           ovf_o,
    input  logic [aw-1:0]  addr_r_i,
    input  logic           r_vi,
    output logic [x_w-1:0] data_r_o,
    output logic           r_vo
);

    localparam logic [aw:0] LAST = (aw+1)'(depth - 1);
    localparam logic [aw:0] ONE  = (aw+1)'(1);

    wbuf_state_t state_q, state_d;
    logic [aw:0] ptr_q, ptr_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        we;

    // Next state: clear wins over any sample, then fill, then overflow.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        we      = 1'b0;
        priority case (1'b1)
            clear_i: begin
                state_d = FILL;
                ptr_d   = '0;
                ovf_d   = 1'b0;
            end
            v_vi && (state_q == FILL): begin
                we    = 1'b1;
                ptr_d = ptr_q + ONE;
                if (ptr_q == LAST) begin
                    state_d = FULL;
                    done_d  = 1'b1;
                end
            end
            v_vi: begin
                ovf_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Capture state, pointer and flag registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FILL;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign cnt_o   = ptr_q;
    assign full_o  = (state_q == FULL);
    assign done_vo = done_q;
    assign ovf_o   = ovf_q;

    buf_regfile #(
        .x_w   (x_w),
        .depth (depth)
    ) u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .waddr_i (ptr_q[aw-1:0]),
        .wdata_i (d_i),
        .re_i    (r_vi),
        .raddr_i (addr_r_i),
        .rdata_o (data_r_o),
        .rv_o    (r_vo)
    );

endmodule

// File: tb/tb_write_buf.sv
// Bench for write_buf: directed scenarios plus random traffic
// checked against a queue-based frame model.
module tb_write_buf;

    localparam int XW = 16;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [XW-1:0] d_i = '0;
    logic          v_vi = 1'b0;
    logic          clear_i = 1'b0;
    logic [AW:0]   cnt_o;
    logic          full_o;
    logic          done_vo;
    logic          ovf_o;
    logic [AW-1:0] addr_r_i = '0;
    logic          r_vi = 1'b0;
    logic [XW-1:0] data_r_o;
    logic          r_vo;

    write_buf #(.x_w(XW), .depth(D)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .d_i      (d_i),
        .v_vi     (v_vi),
        .clear_i  (clear_i),
        .cnt_o    (cnt_o),
        .full_o   (full_o),
        .done_vo  (done_vo),
        .ovf_o    (ovf_o),
        .addr_r_i (addr_r_i),
        .r_vi     (r_vi),
        .data_r_o (data_r_o),
        .r_vo     (r_vo)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int done_seen = 0;

    // Reference model: the frame as a queue, memory as an array.
    logic [XW-1:0] mmem [D];
    bit            mk [D];
    logic [XW-1:0] frame [$];
    bit            e_done;
    bit            e_ovf;
    bit            e_rv;
    bit            e_rk;
    logic [XW-1:0] e_rdata;

    task automatic model_reset();
        frame.delete();
        e_done  = 0;
        e_ovf   = 0;
        e_rv    = 0;
        e_rk    = 1;
        e_rdata = '0;
    endtask

    // One clock: drive at negedge, update model at the edge.
    task automatic step(input bit v, input logic [XW-1:0] d,
                        input bit clr, input bit rv, input int ra);
        logic [AW-1:0] a;
        a = ra[AW-1:0];
        v_vi = v;
        d_i = d;
        clear_i = clr;
        r_vi = rv;
        addr_r_i = a;
        @(posedge clk_i);
        if (rv) begin
            e_rv = 1;
            if (ra < D) begin
                e_rdata = mmem[ra];
                e_rk = mk[ra];
            end else begin
                e_rdata = '0;
                e_rk = 1;
            end
        end else begin
            e_rv = 0;
        end
        e_done = 0;
        if (clr) begin
            frame.delete();
            e_ovf = 0;
        end else if (v) begin
            if (frame.size() < D) begin
                mmem[frame.size()] = d;
                mk[frame.size()] = 1;
                frame.push_back(d);
                e_done = (frame.size() == D);
            end else begin
                e_ovf = 1;
            end
        end
        @(negedge clk_i);
        v_vi = 0;
        clear_i = 0;
        r_vi = 0;
        if (done_vo) done_seen++;
    endtask

    task automatic test_reset();
        rst_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        total++;
        if ({cnt_o, full_o, done_vo, ovf_o, r_vo} !== '0
            || data_r_o !== '0) begin
            bad++;
            $display("FAIL reset cnt=%0d full=%b done=%b ovf=%b rv=%b data=%h exp all 0",
                     cnt_o, full_o, done_vo, ovf_o, r_vo, data_r_o);
        end
        rst_i = 1;
        @(negedge clk_i);
    endtask

    task automatic test_dense();
        int d0;
        d0 = done_seen;
        for (int i = 0; i < D; i++) begin
            step(1, XW'(16'h0010 + i), 0, 0, 0);
            total++;
            if (cnt_o !== (AW+1)'(i + 1) || done_vo !== (i == D - 1)) begin
                bad++;
                $display("FAIL dense_fill i=%0d cnt=%0d done=%b exp cnt=%0d done=%b",
                         i, cnt_o, done_vo, i + 1, (i == D - 1));
            end
        end
        total++;
        if (full_o !== 1'b1) begin
            bad++;
            $display("FAIL dense_full got=%b exp=1", full_o);
        end
        for (int i = 0; i < D; i++) begin
            step(0, '0, 0, 1, i);
            total++;
            if (r_vo !== 1'b1 || data_r_o !== XW'(16'h0010 + i)) begin
                bad++;
                $display("FAIL dense_read a=%0d data=%h rv=%b exp data=%h rv=1",
                         i, data_r_o, r_vo, 16'h0010 + i);
            end
        end
        step(0, '0, 0, 0, 0);
        total++;
        if (r_vo !== 1'b0 || done_seen - d0 !== 1 || cnt_o !== 4'd8) begin
            bad++;
            $display("FAIL dense_after rv=%b dones=%0d cnt=%0d exp rv=0 dones=1 cnt=8",
                     r_vo, done_seen - d0, cnt_o);
        end
    endtask

    task automatic test_ovf();
        step(1, 16'hBEEF, 0, 1, 0);
        total++;
        if (ovf_o !== 1'b1 || cnt_o !== 4'd8 || data_r_o !== 16'h0010) begin
            bad++;
            $display("FAIL ovf_set ovf=%b cnt=%0d data=%h exp ovf=1 cnt=8 data=0010",
                     ovf_o, cnt_o, data_r_o);
        end
        step(0, '0, 0, 1, 0);
        total++;
        if (ovf_o !== 1'b1 || data_r_o !== 16'h0010 || done_vo !== 1'b0) begin
            bad++;
            $display("FAIL ovf_sticky ovf=%b data=%h done=%b exp ovf=1 data=0010 done=0",
                     ovf_o, data_r_o, done_vo);
        end
        step(0, '0, 1, 0, 0);
        total++;
        if (ovf_o !== 1'b0 || cnt_o !== 4'd0 || full_o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear ovf=%b cnt=%0d full=%b exp 0 0 0",
                     ovf_o, cnt_o, full_o);
        end
    endtask

    task automatic test_gapped();
        int d0;
        int k;
        d0 = done_seen;
        k = 0;
        while (k < D) begin
            step(1, XW'(16'h0020 + k), 0, 0, 0);
            k++;
            if (k < D) begin
                step(0, '0, 0, 0, 0);
                step(0, '0, 0, 0, 0);
            end
        end
        total++;
        if (done_vo !== 1'b1 || full_o !== 1'b1 || cnt_o !== 4'd8) begin
            bad++;
            $display("FAIL gap_done done=%b full=%b cnt=%0d exp 1 1 8",
                     done_vo, full_o, cnt_o);
        end
        for (int i = 0; i < D; i++) begin
            step(0, '0, 0, 1, i);
            total++;
            if (data_r_o !== XW'(16'h0020 + i) || r_vo !== 1'b1) begin
                bad++;
                $display("FAIL gap_read a=%0d data=%h exp=%h",
                         i, data_r_o, 16'h0020 + i);
            end
        end
        total++;
        if (done_seen - d0 !== 1) begin
            bad++;
            $display("FAIL gap_dones got=%0d exp=1", done_seen - d0);
        end
        step(0, '0, 1, 0, 0);
    endtask

    task automatic test_clear_last();
        int d0;
        d0 = done_seen;
        for (int i = 0; i < D - 1; i++) step(1, XW'(16'h0030 + i), 0, 0, 0);
        step(1, 16'h0037, 1, 0, 0);
        total++;
        if (done_vo !== 1'b0 || cnt_o !== 4'd0 || full_o !== 1'b0) begin
            bad++;
            $display("FAIL clr_last done=%b cnt=%0d full=%b exp 0 0 0",
                     done_vo, cnt_o, full_o);
        end
        step(1, 16'h00AA, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        total++;
        if (data_r_o !== 16'h00AA || cnt_o !== 4'd1 || done_seen !== d0) begin
            bad++;
            $display("FAIL clr_next data=%h cnt=%0d dones=%0d exp 00aa 1 0",
                     data_r_o, cnt_o, done_seen - d0);
        end
    endtask

    task automatic test_rbw();
        logic [XW-1:0] old;
        step(1, 16'h0001, 0, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        old = mmem[3];
        step(1, 16'h0055, 0, 1, 3);
        total++;
        if (data_r_o !== 16'h0033 || data_r_o !== old) begin
            bad++;
            $display("FAIL rbw_old data=%h exp=%h", data_r_o, old);
        end
        step(0, '0, 0, 1, 3);
        total++;
        if (data_r_o !== 16'h0055 || r_vo !== 1'b1) begin
            bad++;
            $display("FAIL rbw_new data=%h rv=%b exp 0055 1", data_r_o, r_vo);
        end
        step(0, '0, 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, XW'(16'h0040 + i), 0, 0, 0);
        r_vi = 1;
        addr_r_i = 3'd2;
        #2;
        rst_i = 0;
        #1;
        total++;
        if ({cnt_o, full_o, done_vo, ovf_o, r_vo} !== '0
            || data_r_o !== '0) begin
            bad++;
            $display("FAIL rst_mid cnt=%0d full=%b done=%b ovf=%b rv=%b data=%h exp all 0",
                     cnt_o, full_o, done_vo, ovf_o, r_vo, data_r_o);
        end
        @(negedge clk_i);
        r_vi = 0;
        rst_i = 1;
        model_reset();
        total++;
        if (r_vo !== 1'b0 || cnt_o !== 4'd0) begin
            bad++;
            $display("FAIL rst_lost rv=%b cnt=%0d exp 0 0", r_vo, cnt_o);
        end
        for (int i = 0; i < D; i++) step(1, XW'(16'h0060 + i), 0, 0, 0);
        total++;
        if (cnt_o !== 4'd8 || full_o !== 1'b1 || done_vo !== 1'b1) begin
            bad++;
            $display("FAIL rst_refill cnt=%0d full=%b done=%b exp 8 1 1",
                     cnt_o, full_o, done_vo);
        end
        step(0, '0, 1, 0, 0);
    endtask

    task automatic test_random();
        int n_bad;
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) < 55, XW'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, D - 1));
            n_bad = 0;
            if (cnt_o !== (AW+1)'(frame.size())) n_bad++;
            if (full_o !== (frame.size() == D)) n_bad++;
            if (done_vo !== e_done) n_bad++;
            if (ovf_o !== e_ovf) n_bad++;
            if (r_vo !== e_rv) n_bad++;
            if (e_rv && e_rk && data_r_o !== e_rdata) n_bad++;
            total++;
            if (n_bad != 0) begin
                bad++;
                $display("FAIL rand c=%0d cnt=%0d/%0d full=%b done=%b/%b ovf=%b/%b rv=%b/%b data=%h/%h",
                         c, cnt_o, frame.size(), full_o, done_vo, e_done,
                         ovf_o, e_ovf, r_vo, e_rv, data_r_o, e_rdata);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            mk[i] = 0;
            mmem[i] = '0;
        end
        @(negedge clk_i);
        test_reset();
        test_dense();
        test_ovf();
        test_gapped();
        test_clear_last();
        test_rbw();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_buf.md
# write_buf

Capture buffer at the output end of the array datapath. Collects a stream of `depth` valid-qualified samples into a register array in arrival order, then flags completion. Holds the captured frame for random-access readout by address until cleared. It is the receiving counterpart to the address-written, start-triggered streaming input buffer that feeds the array.

## Interface
- `x_w`, default 16: sample width in bits.
- `depth`, default 8: samples per frame; ≥2, need not be a power of two.
- `aw`, derived, $clog2(depth): address width.

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `d_i` input x_w: incoming sample.
- `v_vi` input 1: `d_i` valid this cycle.
- `clear_i` input 1: discard the frame and re-arm capture.
- `cnt_o` output aw+1: number of samples captured in the current frame, 0..depth.
- `full_o` output 1: level; frame complete and held.
- `done_vo` output 1: one-cycle pulse when the frame completes.
- `ovf_o` output 1: sticky; a sample arrived while full.
- `addr_r_i` input aw: read address.
- `r_vi` input 1: read request.
- `data_r_o` output x_w: read data.
- `r_vo` output 1: `data_r_o` valid.

## Operation
- Two states, held in a registered state variable:
  - FILL: accepting samples.
  - FULL: holding a complete frame.
- Reset state is FILL with write pointer 0.
- FILL:
  - Each cycle with `v_vi`=1 writes `d_i` to `mem[wr_ptr]` and increments `wr_ptr`.
  - The write that makes `wr_ptr` reach `depth` moves the block to FULL.
  - `v_vi`=0 leaves the block unchanged.
- FULL:
  - `v_vi`=1 writes nothing and sets `ovf_o`.
  - `wr_ptr` stays at `depth`.
- `clear_i`=1, in any state:
  - Next state is FILL, `wr_ptr` goes to 0, `ovf_o` clears.
  - `clear_i` takes priority over a simultaneous `v_vi`. That sample is dropped and is not counted as an overflow.
  - Memory contents are not erased.
- `cnt_o` equals `wr_ptr`.
- `full_o` is 1 exactly when the state is FULL.
- Reads are independent of capture state and are allowed in FILL to observe a partial frame.
  - `r_vi`=1 captures `mem[addr_r_i]` into `data_r_o`.
  - If `addr_r_i` ≥ `depth`, `data_r_o` is 0 and `r_vo` still asserts.
  - `r_vi`=0 holds `data_r_o` at its last value and drives `r_vo` to 0.
- Read and write to the same address in the same cycle: the read returns the old content, i.e. read-before-write.
- Memory has no reset. Content before the first write to an address is don't-care; the bench must not check it.

## Timing
- Reset values:
  - Outputs: `cnt_o`=0, `full_o`=0, `done_vo`=0, `ovf_o`=0, `data_r_o`=0, `r_vo`=0.
  - Internal: state FILL, `wr_ptr`=0.
- Write latency:
  - A sample presented in cycle t is readable by a read issued in cycle t+1.
  - `cnt_o` reflects the sample from cycle t+1.
- Completion:
  - Last sample accepted in cycle t → `full_o`=1 and `done_vo`=1 in cycle t+1.
  - `done_vo` returns to 0 in t+2 and pulses exactly once per frame.
- Overflow: `v_vi` in FULL at cycle t → `ovf_o`=1 from t+1 until `clear_i` or reset.
- Clear: `clear_i` at cycle t → `cnt_o`=0, `full_o`=0, `ovf_o`=0 from t+1. A `v_vi` at t+1 is accepted into address 0.
- Clear in the completion cycle: `clear_i` together with the final `v_vi` means no `done_vo`, `cnt_o`=0.
- Read latency is 1 cycle: `r_vi` at t → `data_r_o` and `r_vo`=1 at t+1. Back-to-back reads give one result per cycle.
- Reset mid-frame:
  - All registers return to reset values asynchronously.
  - A pending read is lost and `r_vo`=0.

## Structure
- Shared package `sa_pkg`:
  - `typedef enum logic {FILL, FULL} wbuf_state_t;`
  - Common width constants shared with the input buffer.
- One sub-module `buf_regfile`:
  - Parameterised `x_w`/`depth`.
  - One synchronous write port.
  - One registered read port with read-before-write behaviour and out-of-range read returning 0.
  - No reset on storage.
- Top level holds the FSM, the write pointer, and the flag registers.

## Test plan
- Reset, then 8 consecutive `v_vi` samples 0x0010..0x0017:
  - `done_vo` pulses once, one cycle after the last sample; `full_o`=1, `cnt_o`=8.
  - Reads of addr 0..7 return 0x0010..0x0017, each 1 cycle after request.
- Gapped stream, `v_vi` every third cycle: capture order and completion are identical to the dense case, `done_vo` exactly once.
- Extra `v_vi` with 0xBEEF while FULL:
  - `ovf_o`=1 sticky, `cnt_o` stays 8, addr 0 still reads 0x0010.
  - `clear_i` then drops `ovf_o`.
- `clear_i` asserted together with the 8th sample: no `done_vo`, `cnt_o`=0. The next sample 0x00AA lands at addr 0.
- Read addr 3 in the cycle 0x0055 is written there: returns the old value; a read in the next cycle returns 0x0055.
- `rst_i` low after 5 samples: all outputs 0 immediately. After release, a full new frame completes normally with `cnt_o`=8.
